// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiply unit: operation modes and
// controller states, imported by the unit and by the core controller decode.
package mul_pkg;

   localparam logic [1:0] MODE_MUL   = 2'b00;
   localparam logic [1:0] MODE_MLA   = 2'b01;
   localparam logic [1:0] MODE_UMULL = 2'b10;
   localparam logic [1:0] MODE_SMULL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiply / multiply-accumulate unit (MUL, MLA, UMULL,
// SMULL). One multiplier bit retired per cycle, then a sign/accumulate fix-up.
module mul_iter_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [1:0]       flags
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   // Magnitude of a two's-complement operand; the most-negative value maps to
   // 2^(WIDTH-1), which is still representable as an unsigned operand.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] neg_v;
      neg_v = -v;
      return v[WIDTH-1] ? $unsigned(neg_v) : $unsigned(v);
   endfunction

   function automatic logic [PW-1:0] fix_result(input logic [1:0]       m,
                                                input logic             neg,
                                                input logic [PW-1:0]    p,
                                                input logic [WIDTH-1:0] addend);
      logic [PW-1:0] r;
      case (m)
         MODE_MUL:   r = {{WIDTH{1'b0}}, p[WIDTH-1:0]};
         MODE_MLA:   r = {{WIDTH{1'b0}}, p[WIDTH-1:0] + addend};
         MODE_UMULL: r = p;
         default:    r = neg ? (PW'(0) - p) : p;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] flags_of(input logic [1:0] m, input logic [PW-1:0] r);
      logic n;
      logic z;
      if (m == MODE_MUL || m == MODE_MLA) begin
         n = r[WIDTH-1];
         z = (r[WIDTH-1:0] == '0);
      end else begin
         n = r[PW-1];
         z = (r == '0);
      end
      return {n, z};
   endfunction

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        mode_q;
   logic [WIDTH-1:0]  acc_q;
   logic              neg_q;
   logic [PW-1:0]     mcand;
   logic [WIDTH-1:0]  mplier;
   logic [PW-1:0]     prod;
   logic [CNT_W-1:0]  cnt;
   logic              load;
   logic [PW-1:0]     fix_res;

   assign load    = start && (state == IDLE || state == DONE);
   assign fix_res = fix_result(mode_q, neg_q, prod, acc_q);
   assign busy    = (state == RUN) || (state == FIX);
   assign done    = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q    <= MODE_MUL;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         cnt       <= '0;
         result_lo <= '0;
         result_hi <= '0;
         flags     <= 2'b00;
      end else begin
         if (load) begin
            mode_q <= mode;
            acc_q  <= acc;
            prod   <= '0;
            cnt    <= '0;
            if (mode == MODE_SMULL) begin
               mcand  <= {{WIDTH{1'b0}}, magnitude(a)};
               mplier <= magnitude(b);
               neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
               mcand  <= {{WIDTH{1'b0}}, a};
               mplier <= b;
               neg_q  <= 1'b0;
            end
         end else if (state == RUN) begin
            // Multiplicand walks left while the multiplier walks right, so
            // bit 0 of mplier is always multiplier bit[cnt].
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
         end

         if (state == FIX) begin
            result_lo <= fix_res[WIDTH-1:0];
            result_hi <= fix_res[PW-1:WIDTH];
            flags     <= flags_of(mode_q, fix_res);
         end
      end
   end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit at WIDTH=32 and WIDTH=8: a vector table
// plus hand-written sequences for mid-run start, back-to-back and reset abort.
module tb_mul_iter_unit;
   import mul_pkg::*;

   typedef struct {
      int          w;
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] acc;
      logic [31:0] lo;
      logic [31:0] hi;
      logic [1:0]  fl;
   } vec_t;

   localparam int NV = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start32 = 1'b0, start8 = 1'b0;
   logic [1:0]  mode32 = '0, mode8 = '0;
   logic [31:0] a32 = '0, b32 = '0, acc32 = '0;
   logic [7:0]  a8 = '0, b8 = '0, acc8 = '0;
   logic        busy32, done32, busy8, done8;
   logic [31:0] lo32, hi32;
   logic [7:0]  lo8, hi8;
   logic [1:0]  fl32, fl8;

   int total = 0;
   int bad = 0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   mul_iter_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst_n), .start(start32), .mode(mode32),
      .a(a32), .b(b32), .acc(acc32), .busy(busy32), .done(done32),
      .result_lo(lo32), .result_hi(hi32), .flags(fl32)
   );

   mul_iter_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst_n), .start(start8), .mode(mode8),
      .a(a8), .b(b8), .acc(acc8), .busy(busy8), .done(done8),
      .result_lo(lo8), .result_hi(hi8), .flags(fl8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic sample(input int w, output logic bs, output logic dn,
                         output logic [31:0] lo, output logic [31:0] hi, output logic [1:0] fl);
      if (w == 32) begin
         bs = busy32; dn = done32; lo = lo32; hi = hi32; fl = fl32;
      end else begin
         bs = busy8; dn = done8; lo = {24'b0, lo8}; hi = {24'b0, hi8}; fl = fl8;
      end
   endtask

   task automatic drive(input int w, input logic st, input logic [1:0] m,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
      if (w == 32) begin
         start32 = st; mode32 = m; a32 = av; b32 = bv; acc32 = cv;
      end else begin
         start8 = st; mode8 = m; a8 = av[7:0]; b8 = bv[7:0]; acc8 = cv[7:0];
      end
   endtask

   task automatic check_idle_zero(input int w, input string tag);
      logic bs, dn;
      logic [31:0] lo, hi;
      logic [1:0] fl;
      sample(w, bs, dn, lo, hi, fl);
      check({tag, ".busy"}, 64'(bs), 64'd0);
      check({tag, ".done"}, 64'(dn), 64'd0);
      check({tag, ".lo"}, 64'(lo), 64'd0);
      check({tag, ".hi"}, 64'(hi), 64'd0);
      check({tag, ".flags"}, 64'(fl), 64'd0);
   endtask

   // Start is asserted now and sampled at the next rising edge (E0); checks
   // busy after E0, no done after E0+W, and done plus results after E0+W+1.
   task automatic launch(input vec_t v, input string tag);
      logic bs, dn;
      logic [31:0] lo, hi;
      logic [1:0] fl;
      drive(v.w, 1'b1, v.mode, v.a, v.b, v.acc);
      @(posedge clk); #1;
      drive(v.w, 1'b0, v.mode, v.a, v.b, v.acc);
      sample(v.w, bs, dn, lo, hi, fl);
      check({tag, ".busy_after_start"}, 64'(bs), 64'd1);
      repeat (v.w) @(posedge clk);
      #1;
      sample(v.w, bs, dn, lo, hi, fl);
      check({tag, ".done_early"}, 64'(dn), 64'd0);
      @(posedge clk); #1;
      sample(v.w, bs, dn, lo, hi, fl);
      check({tag, ".done"}, 64'(dn), 64'd1);
      check({tag, ".busy_at_done"}, 64'(bs), 64'd0);
      check({tag, ".lo"}, 64'(lo), 64'(v.lo));
      check({tag, ".hi"}, 64'(hi), 64'(v.hi));
      check({tag, ".flags"}, 64'(fl), 64'(v.fl));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      launch(v, tag);
   endtask

   task automatic mid_run_start(input int w, input string tag);
      logic bs, dn;
      logic [31:0] lo, hi;
      logic [1:0] fl;
      @(negedge clk);
      drive(w, 1'b1, MODE_MUL, 32'd7, 32'd6, 32'd0);
      @(posedge clk); #1;
      drive(w, 1'b0, MODE_MUL, 32'd7, 32'd6, 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      drive(w, 1'b1, MODE_UMULL, 32'h0000_0055, 32'h0000_0033, 32'd9);
      @(posedge clk); #1;
      drive(w, 1'b0, MODE_UMULL, 32'h0000_0055, 32'h0000_0033, 32'd9);
      repeat (w - 5) @(posedge clk);
      @(posedge clk); #1;
      sample(w, bs, dn, lo, hi, fl);
      check({tag, ".done"}, 64'(dn), 64'd1);
      check({tag, ".lo"}, 64'(lo), 64'd42);
      check({tag, ".hi"}, 64'(hi), 64'd0);
      @(posedge clk); #1;
      sample(w, bs, dn, lo, hi, fl);
      check({tag, ".no_queued_op"}, 64'(bs), 64'd0);
   endtask

   task automatic reset_abort(input int w, input int iters, input vec_t after, input string tag);
      logic bs, dn;
      logic [31:0] lo, hi;
      logic [1:0] fl;
      logic seen;
      @(negedge clk);
      drive(w, 1'b1, MODE_UMULL, 32'h0000_00F3, 32'h0000_00A5, 32'd0);
      @(posedge clk); #1;
      drive(w, 1'b0, MODE_UMULL, 32'h0000_00F3, 32'h0000_00A5, 32'd0);
      repeat (iters) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_zero(w, {tag, ".in_reset"});
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < w + 4; i++) begin
         @(posedge clk); #1;
         sample(w, bs, dn, lo, hi, fl);
         if (dn || bs) seen = 1'b1;
      end
      check({tag, ".no_done_after_abort"}, 64'(seen), 64'd0);
      check_idle_zero(w, {tag, ".after_release"});
      run_vec(after, {tag, ".next_op"});
   endtask

   initial begin
      vecs[0]  = '{32, MODE_MUL,   32'd7,         32'd6,         32'd0,  32'd42,        32'd0,         2'b00};
      vecs[1]  = '{32, MODE_MLA,   32'd3,         32'd5,         32'd10, 32'd25,        32'd0,         2'b00};
      vecs[2]  = '{32, MODE_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0,  32'd0,         32'd0,         2'b01};
      vecs[3]  = '{32, MODE_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'h0000_0001, 32'hFFFF_FFFE, 2'b10};
      vecs[4]  = '{32, MODE_SMULL, 32'hFFFF_FFFF, 32'd2,         32'd0,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b10};
      vecs[5]  = '{32, MODE_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0,  32'd0,         32'h4000_0000, 2'b00};
      vecs[6]  = '{32, MODE_MLA,   32'hFFFF_FFFF, 32'd1,         32'd1,  32'd0,         32'd0,         2'b01};
      vecs[7]  = '{32, MODE_MUL,   32'd3,         32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFFD, 32'd0,         2'b10};
      vecs[8]  = '{32, MODE_SMULL, 32'd3,         32'hFFFF_FFFB, 32'd0,  32'hFFFF_FFF1, 32'hFFFF_FFFF, 2'b10};
      vecs[9]  = '{32, MODE_UMULL, 32'h1234_5678, 32'h0000_0010, 32'd0,  32'h2345_6780, 32'h0000_0001, 2'b00};
      vecs[10] = '{8,  MODE_MUL,   32'h07,        32'h06,        32'h00, 32'h2A,        32'h00,        2'b00};
      vecs[11] = '{8,  MODE_MLA,   32'h03,        32'h05,        32'h0A, 32'h19,        32'h00,        2'b00};
      vecs[12] = '{8,  MODE_MUL,   32'h10,        32'h10,        32'h00, 32'h00,        32'h00,        2'b01};
      vecs[13] = '{8,  MODE_UMULL, 32'hFF,        32'hFF,        32'h00, 32'h01,        32'hFE,        2'b10};
      vecs[14] = '{8,  MODE_SMULL, 32'hFF,        32'h02,        32'h00, 32'hFE,        32'hFF,        2'b10};
      vecs[15] = '{8,  MODE_SMULL, 32'h80,        32'h80,        32'h00, 32'h00,        32'h40,        2'b00};
      vecs[16] = '{8,  MODE_SMULL, 32'h03,        32'hFB,        32'h00, 32'hF1,        32'hFF,        2'b10};
      vecs[17] = '{8,  MODE_SMULL, 32'h7F,        32'h81,        32'h00, 32'hFF,        32'hC0,        2'b10};
      vecs[18] = '{8,  MODE_MLA,   32'hFF,        32'h01,        32'h01, 32'h00,        32'h00,        2'b01};
      vecs[19] = '{8,  MODE_SMULL, 32'hFE,        32'hFD,        32'h00, 32'h06,        32'h00,        2'b00};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero(32, "reset32");
      check_idle_zero(8, "reset8");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      mid_run_start(32, "midstart32");
      mid_run_start(8, "midstart8");

      // Back-to-back: second start raised in the DONE cycle of the first.
      run_vec(vecs[3], "b2b32.first");
      launch(vecs[8], "b2b32.second");
      run_vec(vecs[13], "b2b8.first");
      launch(vecs[17], "b2b8.second");

      reset_abort(32, 10, vecs[9], "abort32");
      reset_abort(8, 5, vecs[16], "abort8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
